// File: rtl/enc_layer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : enc_layer_ctrl_if
// Brief    : Handshake and data bus bundle for the encoder layer controller.
// Revision : 1.0 - initial release
// ============================================================================
interface enc_layer_ctrl_if #(
    parameter int BITSIZE = 16,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 6
);
    localparam int c_row_w = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [BITSIZE*N_IN-1:0]       x;
    logic [BITSIZE*N_IN*N_OUT-1:0] w;
    logic [BITSIZE*N_OUT-1:0]      b;
    logic                          out_valid;
    logic                          out_ready;
    logic [BITSIZE*N_OUT-1:0]      y;
    logic                          busy;
    logic [c_row_w-1:0]            row_idx;

    // Environment side: feature source, weight store and downstream stage
    modport master (
        output in_valid, x, w, b, out_ready,
        input  in_ready, out_valid, y, busy, row_idx
    );

    // Controller side
    modport slave (
        input  in_valid, x, w, b, out_ready,
        output in_ready, out_valid, y, busy, row_idx
    );
endinterface
`default_nettype wire

// File: rtl/enc_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enc_layer_ctrl
// Brief    : Row-serial MAC sequencer for one fully connected layer y = b + W*x.
// Revision : 1.0 - initial release
// ============================================================================
module enc_layer_ctrl #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int N_IN    = 10,
    parameter int N_OUT   = 6
) (
    input  wire logic       clk,
    input  wire logic       reset,
    enc_layer_ctrl_if.slave bus
);
    localparam int                 c_row_w    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(N_IN - 1);
    localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic signed [BITSIZE-1:0] fixed_point_multiply(
        input logic signed [BITSIZE-1:0] a,
        input logic signed [BITSIZE-1:0] m
    );
        logic signed [2*BITSIZE-1:0] p;
        p = a * m;
        p = p >>> FRAC;
        return p[BITSIZE-1:0];
    endfunction

    function automatic logic signed [BITSIZE-1:0] fixed_point_add(
        input logic signed [BITSIZE-1:0] a,
        input logic signed [BITSIZE-1:0] c
    );
        return a + c;
    endfunction

    state_t                     r_state;
    state_t                     w_next;
    logic [c_row_w-1:0]         r_row;
    logic signed [BITSIZE-1:0]  r_x        [N_IN];
    logic signed [BITSIZE-1:0]  r_acc      [N_OUT];
    logic signed [BITSIZE-1:0]  r_y        [N_OUT];
    logic signed [BITSIZE-1:0]  w_x_in     [N_IN];
    logic signed [BITSIZE-1:0]  w_b_in     [N_OUT];
    logic signed [BITSIZE-1:0]  w_acc_next [N_OUT];
    logic signed [BITSIZE-1:0]  w_x_cur;
    logic [BITSIZE*N_OUT-1:0]   w_y_packed;
    logic [c_row_w-1:0]         w_row_idx;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_in_ready;
    logic                       w_out_valid;
    logic                       w_busy;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_row_idx   = '0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_row_idx = r_row;
                if (r_row == c_row_last) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus unpacking and per-lane MAC
    // ------------------------------------------------------------------------
    generate
        for (genvar r = 0; r < N_IN; r++) begin : g_x_unpack
            assign w_x_in[r] = bus.x[BITSIZE*r +: BITSIZE];
        end

        for (genvar k = 0; k < N_OUT; k++) begin : g_lane
            logic signed [BITSIZE-1:0] w_col [N_IN];

            for (genvar r = 0; r < N_IN; r++) begin : g_col
                assign w_col[r] = bus.w[BITSIZE*(r*N_OUT+k) +: BITSIZE];
            end

            assign w_b_in[k]     = bus.b[BITSIZE*k +: BITSIZE];
            assign w_acc_next[k] = fixed_point_add(r_acc[k],
                                       fixed_point_multiply(w_x_cur, w_col[r_row]));
        end
    endgenerate

    assign w_x_cur = r_x[r_row];

    // ------------------------------------------------------------------------
    // Datapath registers; row counter parks at zero outside RUN
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_x[i] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                r_acc[k] <= '0;
                r_y[k]   <= '0;
            end
        end else if (w_accept) begin
            r_row <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_x[i] <= w_x_in[i];
            end
            for (int k = 0; k < N_OUT; k++) begin
                r_acc[k] <= w_b_in[k];
            end
        end else if (r_state == S_RUN) begin
            for (int k = 0; k < N_OUT; k++) begin
                r_acc[k] <= w_acc_next[k];
            end
            if (w_last) begin
                r_row <= '0;
                for (int k = 0; k < N_OUT; k++) begin
                    r_y[k] <= w_acc_next[k];
                end
            end else begin
                r_row <= r_row + c_row_one;
            end
        end
    end

    always_comb begin
        w_y_packed = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_y_packed[BITSIZE*k +: BITSIZE] = r_y[k];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.row_idx   = w_row_idx;
    assign bus.y         = w_y_packed;

endmodule
`default_nettype wire

// File: tb/tb_enc_layer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enc_layer_ctrl
// Brief    : Directed self-checking bench for enc_layer_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enc_layer_ctrl;
    localparam int BITSIZE = 16;
    localparam int FRAC    = 8;
    localparam int N_IN    = 10;
    localparam int N_OUT   = 6;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    enc_layer_ctrl_if #(.BITSIZE(BITSIZE), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    enc_layer_ctrl #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC),
        .N_IN    (N_IN),
        .N_OUT   (N_OUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] lane(input int k);
        return bus.y[BITSIZE*k +: BITSIZE];
    endfunction

    task automatic load_uniform(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int r = 0; r < N_IN; r++) bus.x[BITSIZE*r +: BITSIZE] = xv;
        for (int i = 0; i < N_IN*N_OUT; i++) bus.w[BITSIZE*i +: BITSIZE] = wv;
        for (int k = 0; k < N_OUT; k++) bus.b[BITSIZE*k +: BITSIZE] = bv;
    endtask

    task automatic accept();
        bus.in_valid = 1'b1;
        step(1);
        bus.in_valid = 1'b0;
    endtask

    // Returns number of cycles after the accept edge until out_valid is seen
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        load_uniform(16'h0000, 16'h0000, 16'h0000);
        step(2);

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy), 32'd0);
        check("rst_row_idx",   32'(bus.row_idx), 32'd0);
        check("rst_y",         32'(bus.y[31:0]), 32'd0);
        @(negedge clk) reset = 1'b0;
        step(1);

        // Baseline: 10 * (1.0 * 0.5) = 5.0
        load_uniform(16'h0100, 16'h0080, 16'h0000);
        accept();
        check("base_row0",     32'(bus.row_idx), 32'd0);
        check("base_busy",     32'(bus.busy), 32'd1);
        check("base_in_ready", 32'(bus.in_ready), 32'd0);
        step(3);
        check("base_row3",     32'(bus.row_idx), 32'd3);
        wait_done(cyc);
        check("base_latency",  32'(cyc + 3), 32'd10);
        for (int k = 0; k < N_OUT; k++) check("base_y", 32'(lane(k)), 32'h0500);
        step(1);
        check("base_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("base_hs_in_ready",  32'(bus.in_ready), 32'd1);

        // Bias only
        load_uniform(16'h0000, 16'h0080, 16'h0000);
        for (int k = 0; k < N_OUT; k++) bus.b[BITSIZE*k +: BITSIZE] = 16'(k * 256);
        accept();
        wait_done(cyc);
        for (int k = 0; k < N_OUT; k++) check("bias_y", 32'(lane(k)), 32'(k * 256));
        step(1);

        // Negative: -2.0 * 1.5 + 1.0 = -2.0
        load_uniform(16'h0000, 16'h0000, 16'h0100);
        bus.x[15:0] = 16'hFE00;
        for (int k = 0; k < N_OUT; k++) bus.w[BITSIZE*k +: BITSIZE] = 16'h0180;
        accept();
        wait_done(cyc);
        for (int k = 0; k < N_OUT; k++) check("neg_y", 32'(lane(k)), 32'hFE00);
        step(1);

        // Truncation toward -inf and wrap on lane 0
        load_uniform(16'h0000, 16'h0000, 16'h0000);
        bus.x[15:0] = 16'h0001;
        bus.w[15:0] = 16'h0001;
        accept();
        wait_done(cyc);
        check("trunc_small_y0", 32'(lane(0)), 32'h0000);
        step(1);
        bus.x[15:0] = 16'h7F00;
        bus.w[15:0] = 16'h0200;
        accept();
        wait_done(cyc);
        check("wrap_y0", 32'(lane(0)), 32'hFE00);
        check("wrap_y1", 32'(lane(1)), 32'h0000);
        step(1);
        bus.x[15:0] = 16'hFFFF;
        bus.w[15:0] = 16'h0001;
        accept();
        wait_done(cyc);
        check("trunc_neg_y0", 32'(lane(0)), 32'hFFFF);
        step(1);

        // Backpressure with ignored in_valid pulses
        load_uniform(16'h0100, 16'h0080, 16'h0000);
        bus.out_ready = 1'b0;
        accept();
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2) == 0;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_y",         32'(lane(2)), 32'h0500);
            check("bp_in_ready",  32'(bus.in_ready), 32'd0);
            check("bp_busy",      32'(bus.busy), 32'd1);
            step(1);
        end
        bus.in_valid  = 1'b0;
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step(1);
        check("bp_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_hs_in_ready",  32'(bus.in_ready), 32'd1);
        check("bp_hs_busy",      32'(bus.busy), 32'd0);

        // Input isolation: x and b scrambled after accept
        load_uniform(16'h0100, 16'h0080, 16'h0000);
        accept();
        for (int r = 0; r < N_IN; r++) bus.x[BITSIZE*r +: BITSIZE] = 16'($urandom);
        for (int k = 0; k < N_OUT; k++) bus.b[BITSIZE*k +: BITSIZE] = 16'($urandom);
        wait_done(cyc);
        for (int k = 0; k < N_OUT; k++) check("iso_y", 32'(lane(k)), 32'h0500);
        step(1);

        // Reset mid-RUN
        load_uniform(16'h0100, 16'h0080, 16'h0000);
        accept();
        step(4);
        check("mid_row4", 32'(bus.row_idx), 32'd4);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready",  32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy",      32'(bus.busy), 32'd0);
        check("mid_rst_row_idx",   32'(bus.row_idx), 32'd0);
        check("mid_rst_y0",        32'(lane(0)), 32'h0000);
        @(negedge clk) reset = 1'b0;
        step(1);
        check("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
        accept();
        wait_done(cyc);
        check("post_rst_latency", 32'(cyc), 32'd10);
        for (int k = 0; k < N_OUT; k++) check("post_rst_y", 32'(lane(k)), 32'h0500);
        step(1);
        check("post_rst_idle", 32'(bus.in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/enc_layer_ctrl.md
# enc_layer_ctrl

Sequencing controller for one fully connected encoder layer, y = b + W·x. It owns the handshake, row counter and per-lane accumulators for a row-serial multiply-accumulate (MAC) array of N_OUT parallel lanes, stepping through one input element per cycle. It sits between the upstream feature source and the next encoder stage and replaces free-running, counter-driven layer evaluation with a start/done valid-ready protocol.

## Interface
- BITSIZE, 16, word width; signed two's complement, Q8.8 at default (FRAC fractional bits)
- FRAC, 8, fractional bits of every word
- N_IN, 10, input vector length (rows of W)
- N_OUT, 6, output vector length (parallel lanes)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  x and b presented and valid
- in_ready  out  1  controller can accept a new vector
- x  in  BITSIZE*N_IN  input vector; element r at [BITSIZE*r +: BITSIZE]
- w  in  BITSIZE*N_IN*N_OUT  weights, row-major; W[r][k] at [BITSIZE*(r*N_OUT+k) +: BITSIZE]; static during operation
- b  in  BITSIZE*N_OUT  bias; b[k] at [BITSIZE*k +: BITSIZE]
- out_valid  out  1  y holds a completed result
- out_ready  in  1  downstream accepts y
- y  out  BITSIZE*N_OUT  result; y[k] at [BITSIZE*k +: BITSIZE]
- busy  out  1  high whenever state is not IDLE
- row_idx  out  ceil(log2(N_IN))  row being accumulated; 0 outside RUN

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture x into an internal register, load acc[k]<=b[k], row<=0, go to RUN.
- RUN:
  - Each cycle, for every k: acc[k] <= acc[k] + mul(x_reg[row], W[row][k]); row <= row+1.
  - In the cycle with row==N_IN-1: perform the last update, load y <= the final acc values, go to DONE.
- DONE:
  - out_valid=1, y stable.
  - On out_ready: go to IDLE.
- mul: full 2*BITSIZE signed product, arithmetic shift right by FRAC, keep the low BITSIZE bits. This truncates toward −∞ and wraps on overflow. No saturation.
- add: BITSIZE-bit two's-complement, wrapping.
- Lane arithmetic uses the team's fixed_point_multiply/fixed_point_add; the width rules above are normative.
- x and b are sampled only at the accept edge. Changes to either during RUN/DONE have no effect.
- w is read live during RUN and must be stable.
- in_valid while in_ready=0 is ignored; no queuing.
- y holds the last completed result until the next RUN→DONE transition. It is only meaningful while out_valid=1.

## Timing
- Reset (asynchronous assert): state=IDLE; in_ready=1, out_valid=0, busy=0, row_idx=0, y=0, all accumulators and x_reg=0.
- Reset has immediate effect mid-RUN or mid-DONE: any in-flight result is discarded and no out_valid is produced for it.
- Latency: with the accept at edge E0, out_valid rises after edge E0+N_IN (10 cycles at default).
- in_ready depends only on state (state==IDLE). There is no combinational path from out_ready to in_ready.
- Output handshake at edge Ed: out_valid=0 and in_ready=1 in the following cycle.
- Minimum accept-to-accept period: N_IN+2 cycles.
- If out_ready is held high, DONE lasts exactly one cycle.
- out_valid never drops without a handshake, except on reset.
- row_idx equals the row used in the current cycle's update. Sequence during RUN is 0..N_IN-1.

## Test plan
- Baseline: x all 0x0100 (1.0), W all 0x0080 (0.5), b all 0, out_ready=1 → out_valid exactly 10 cycles after accept; every y[k]=0x0500 (5.0); in_ready=1 two cycles after the accept cycle count ends.
- Bias only / negative values:
  - x all 0, b[k]=k·0x0100 → y[k]=b[k].
  - Then x[0]=0xFE00 (−2.0), W[0][k]=0x0180 (1.5), all other W 0, b all 0x0100 → y[k]=0xFE00 (−2.0).
- Truncation and wrap:
  - x[0]=0x0001, W[0][0]=0x0001, rest 0, b 0 → y[0]=0x0000.
  - x[0]=0x7F00, W[0][0]=0x0200 → y[0]=0xFE00 (wrapped).
  - x[0]=0xFFFF, W[0][0]=0x0001 → y[0]=0xFFFF.
- Backpressure: out_ready=0 for 5 cycles after out_valid → y, out_valid stable, in_ready=0, busy=1, in_valid pulses ignored; raise out_ready → handshake, then IDLE with in_ready=1 next cycle.
- Input isolation: change x and b to random values during RUN → result matches the values captured at accept.
- Reset mid-operation: assert reset at row_idx=4 → all outputs at reset values immediately; the next transaction (baseline stimulus) yields y[k]=0x0500 with no stale out_valid.
